i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the sample width per channel.
REQ-002 The block SHALL have parameter BCLK_DIV, default 4, the number of clk cycles per bclk half-period (legal range 2..255).
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  run enable; sampled at frame boundaries.
REQ-006 in_valid  input  1  sample pair offered.
REQ-007 in_left  input  DATA_WIDTH  left sample, two's complement.
REQ-008 in_right  input  DATA_WIDTH  right sample, two's complement.
REQ-009 in_ready  output  1  holding register empty; transfer occurs when in_valid and in_ready are both high.
REQ-010 bclk_o  output  1  I2S bit clock.
REQ-011 lrck_o  output  1  I2S word select; 0 selects left, 1 selects right.
REQ-012 sdata_o  output  1  I2S serial data, MSB first.
REQ-013 load_pulse  output  1  one-clk strobe asserted when the shifter loads.
REQ-014 underrun_cnt  output  8  saturating count of loads with no new sample available.

Function
REQ-015 States: IDLE and RUN; IDLE→RUN when en=1; RUN→IDLE only at the wrap from period 2*DATA_WIDTH-1 to 0 with en=0.
REQ-016 In IDLE, bclk_o, lrck_o and sdata_o SHALL be 0, div_cnt SHALL be 0, and the period index SHALL be 0.
REQ-017 div_cnt SHALL count 0..BCLK_DIV-1 in RUN; bclk_o SHALL toggle on each clk where div_cnt=BCLK_DIV-1; bclk_o SHALL be 0 on entry to RUN.
REQ-018 The period index k (0..2*DATA_WIDTH-1) SHALL advance on each bclk falling edge and wrap to 0.
REQ-019 lrck_o SHALL be updated on bclk falling edges: 0 for k in 0..DATA_WIDTH-1, 1 for k in DATA_WIDTH..2*DATA_WIDTH-1.
REQ-020 The shifter SHALL be a 2*DATA_WIDTH-bit register holding {left,right}; sdata_o SHALL equal its MSB and SHALL change only on bclk falling edges.
REQ-021 On the falling edge entering k=1, the shifter SHALL load, producing the standard I2S one-bit delay; all other falling edges SHALL shift left by one, filling with 0.
REQ-022 At load: if the hold register is full, the hold contents SHALL be used and the hold register cleared; if it is empty, the previous pair SHALL be repeated and underrun_cnt SHALL increment, saturating at 255.
REQ-023 load_pulse SHALL be high for exactly the clk cycle on which the load occurs.
REQ-024 in_ready SHALL be high while the hold register is empty, including in IDLE.
REQ-025 When an accept and a load coincide in the same clk, the load SHALL see the register as empty (underrun, repeat); the accepted pair SHALL remain held for the next frame.
REQ-026 sdata_o in period 0 SHALL carry the right-channel LSB of the previous frame; in the first frame after entering RUN, it SHALL carry 0.
REQ-027 Frame rate SHALL be clk / (2*BCLK_DIV*2*DATA_WIDTH).
REQ-028 Deasserting en mid-frame SHALL complete the current frame, including its period 2*DATA_WIDTH-1, before entering IDLE; the hold register SHALL be retained.
REQ-029 The "previous pair" SHALL reset to zero.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately force the state to IDLE and every output to 0, except in_ready, which SHALL be 1.
REQ-031 Reset SHALL clear the shifter, the hold register, the previous pair, div_cnt, the period index and underrun_cnt.
REQ-032 Reset SHALL take effect mid-frame without waiting for a boundary.
REQ-033 Release of reset_n SHALL be synchronized to clk, with a 2-flop release, before the state machine leaves IDLE.

Verification (DATA_WIDTH=16, BCLK_DIV=2)
REQ-034 Pair L=0xA5C3 and R=0x0F0F accepted before en rises -> first load_pulse occurs 4 clk after en and reset settle; decoding sdata_o on bclk rising edges yields left 0xA5C3 while lrck_o=0 and right 0x0F0F while lrck_o=1, with the right LSB in the next frame's period 0.
REQ-035 en=1 with no samples ever offered -> underrun_cnt increments once per 128-clk frame, reaches 255 and holds there, and sdata_o stays 0.
REQ-036 New pair 0x7FFF/0x8000 offered each frame, arriving after load_pulse -> no underrun, in_ready drops for exactly one frame per pair, and output words match the inputs in order.
REQ-037 in_valid raised on the exact load_pulse clk of a frame with the hold register empty -> underrun_cnt increments by 1, the prior pair repeats, and the new pair is emitted in the following frame.
REQ-038 en dropped at period 5 -> the frame completes through period 31, then bclk_o, lrck_o and sdata_o all go 0; en reasserted -> frame restarts at period 0 with the held pair.
REQ-039 reset_n pulsed low at period 20 -> all outputs are 0 within the same clk, underrun_cnt=0, in_ready=1.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry hold register feeding a {left,right} shifter,
// bit clock divided from clk, standard one-bit-delayed I2S framing.
module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    output logic                  in_ready,
    output logic                  bclk_o,
    output logic                  lrck_o,
    output logic                  sdata_o,
    output logic                  load_pulse,
    output logic [7:0]            underrun_cnt
);
    localparam int FW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(FW);
    localparam logic [7:0]    DIV_MAX = 8'(BCLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(FW - 1);
    localparam logic [KW-1:0] K_RIGHT = KW'(DATA_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rst_sync_q;
    logic [7:0]    div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          lrck_q, lrck_d;
    logic [KW-1:0] k_q, k_d;
    logic [FW-1:0] shift_q, shift_d;
    logic [FW-1:0] prev_q, prev_d;
    logic [FW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    under_q, under_d;
    logic          tick, fall, load, accept;

    // Reset asserts everywhere at once; only the release is synchronized,
    // and it merely gates the IDLE->RUN transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            k_q         <= '0;
            shift_q     <= '0;
            prev_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            under_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            k_q         <= k_d;
            shift_q     <= shift_d;
            prev_q      <= prev_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            under_q     <= under_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        k_d         = k_q;
        shift_d     = shift_q;
        prev_d      = prev_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        under_d     = under_q;

        tick   = (state_q == RUN) && (div_q == DIV_MAX);
        fall   = tick && bclk_q;
        load   = fall && (k_q == '0);
        accept = in_valid && !hold_full_q;

        case (state_q)
            IDLE: if (en && rst_sync_q[1]) state_d = RUN;
            RUN: begin
                div_d = tick ? '0 : div_q + 8'd1;
                if (tick) bclk_d = !bclk_q;
                if (fall) begin
                    k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
                    lrck_d  = (k_d >= K_RIGHT);
                    shift_d = {shift_q[FW-2:0], 1'b0};
                    // Loading on the edge into k=1 gives the one-bit I2S delay.
                    if (load) begin
                        shift_d = hold_full_q ? hold_q : prev_q;
                        prev_d  = shift_d;
                    end
                    if (k_q == K_LAST && !en) begin
                        state_d = IDLE;
                        shift_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pair accepted on the load clk is not visible to that load.
        if (load && hold_full_q) hold_full_d = 1'b0;
        if (load && !hold_full_q && under_q != 8'hFF) under_d = under_q + 8'd1;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = {in_left, in_right};
        end
    end

    assign in_ready     = !hold_full_q;
    assign bclk_o       = bclk_q;
    assign lrck_o       = lrck_q;
    assign sdata_o      = shift_q[FW-1];
    assign load_pulse   = load;
    assign underrun_cnt = under_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: random pairs, a frame-level model of hold/underrun
// behaviour, and a serial decoder that rebuilds words from bclk/lrck/sdata.
module tb_i2s_tx;
    localparam int DW    = 16;
    localparam int DIV   = 2;
    localparam int FW    = 2 * DW;
    localparam int FRAME = 2 * DIV * FW;

    logic          clk = 1'b0;
    logic          reset_n, en, in_valid;
    logic [DW-1:0] in_left, in_right;
    logic          in_ready, bclk_o, lrck_o, sdata_o, load_pulse;
    logic [7:0]    underrun_cnt;

    always #5 clk = ~clk;

    i2s_tx #(.DATA_WIDTH(DW), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid),
        .in_left(in_left), .in_right(in_right), .in_ready(in_ready),
        .bclk_o(bclk_o), .lrck_o(lrck_o), .sdata_o(sdata_o),
        .load_pulse(load_pulse), .underrun_cnt(underrun_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic          m_full;
    logic [FW-1:0] m_hold, m_prev, mon_pair;
    int            m_under;
    logic [FW-1:0] exp_q[$];
    logic          mon_acc;
    // Decoder state
    int            p, mon_k, low_cnt, cyc, last_load, sat_ones;
    logic          fresh, pend, bclk_prev, cont, sat_phase;
    logic [DW-1:0] lacc;
    logic [DW-2:0] racc;
    logic [FW-1:0] lrv;

    initial cyc = 0;

    task automatic word_chk(input logic full, input logic [DW-1:0] r);
        logic [FW-1:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("left_word", lacc, e[FW-1:DW]);
            if (full) chk("right_word", r, e[DW-1:0]);
            else      chk("right_part", {r[DW-1:1], 1'b0}, {e[DW-1:1], 1'b0});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_full = 0; m_hold = '0; m_prev = '0; m_under = 0;
            exp_q.delete();
            p = 0; mon_k = -1; fresh = 1; pend = 0; bclk_prev = 0;
            low_cnt = 0; cont = 0;
        end else begin
            mon_acc = in_valid && !m_full;
            if (load_pulse) begin
                chk("underrun", underrun_cnt, m_under);
                chk("ready_at_load", in_ready, !m_full);
                if (cont) chk("frame_len", cyc - last_load, FRAME);
                cont = 1; last_load = cyc;
                mon_pair = m_full ? m_hold : m_prev;
                if (!m_full && m_under < 255) m_under++;
                m_prev = mon_pair;
                exp_q.push_back(mon_pair);
                m_full = 0;
            end
            if (mon_acc) begin
                m_full = 1;
                m_hold = {in_left, in_right};
            end
            if (bclk_o && !bclk_prev) begin
                if (fresh) p = 0;
                if (sat_phase && sdata_o) sat_ones++;
                if (p == 0) begin
                    if (fresh)     chk("p0_first", sdata_o, 0);
                    else if (pend) word_chk(1, {racc, sdata_o});
                    pend = 0; fresh = 0; lrv = '0;
                end
                lrv[p] = lrck_o;
                if (p >= 1 && p <= DW) lacc = {lacc[DW-2:0], sdata_o};
                if (p > DW)            racc = {racc[DW-3:0], sdata_o};
                if (p == FW - 1) begin
                    chk("lrck_pattern", lrv, 32'hFFFF0000);
                    pend = 1;
                end
                mon_k = p;
                p = (p + 1) % FW;
            end
            low_cnt = bclk_o ? 0 : low_cnt + 1;
            // bclk held low longer than a half-period means the block went idle
            if (low_cnt == DIV + 2) begin
                if (pend) word_chk(0, {racc, 1'b0});
                pend = 0; fresh = 1; cont = 0; mon_k = -1;
            end
            bclk_prev = bclk_o;
        end
    end

    task automatic idle_outs(input string tag, input logic ready);
        chk({tag, "_bclk"}, bclk_o, 0);
        chk({tag, "_lrck"}, lrck_o, 0);
        chk({tag, "_sdata"}, sdata_o, 0);
        chk({tag, "_load"}, load_pulse, 0);
        chk({tag, "_ready"}, in_ready, ready);
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n = 0;
        in_left = l; in_right = r; in_valid = 1;
        while (!in_ready && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_load();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!load_pulse && n < 2 * FRAME);
        if (!load_pulse) chk("load_timeout", 0, 1);
    endtask

    task automatic wait_k(input int k);
        int n = 0;
        while (mon_k != k && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        if (mon_k != k) chk("period_timeout", 0, 1);
    endtask

    initial begin
        int u, n;
        reset_n = 0; en = 0; in_valid = 0; in_left = '0; in_right = '0;
        sat_phase = 0; sat_ones = 0;
        repeat (3) @(posedge clk); #1;
        idle_outs("rst", 1);
        chk("rst_under", underrun_cnt, 0);
        reset_n = 1;
        repeat (5) @(posedge clk); #1;

        // First pair held before enable; first load four clks after en
        send(16'hA5C3, 16'h0F0F);
        chk("ready_held", in_ready, 0);
        en = 1;
        repeat (3) @(posedge clk); #1;
        chk("load_early", load_pulse, 0);
        @(posedge clk); #1;
        chk("load_first", load_pulse, 1);
        @(posedge clk); #1;
        chk("ready_after_load", in_ready, 1);
        wait_load();
        wait_load();
        chk("under_repeat", underrun_cnt, 1);
        @(posedge clk); #1;

        // One pair per frame, offered after each load
        for (int i = 0; i < 4; i++) begin
            send(16'h7FFF, 16'h8000);
            repeat (30) @(posedge clk); #1;
            chk("ready_low", in_ready, 0);
            u = underrun_cnt;
            wait_load();
            @(posedge clk); #1;
            chk("ready_high", in_ready, 1);
            chk("no_underrun", underrun_cnt, u);
        end

        // Accept coinciding with a load: load sees an empty register
        u = underrun_cnt;
        wait_load();
        in_left = 16'($urandom()); in_right = 16'($urandom()); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("coincide_under", underrun_cnt, u + 1);
        chk("coincide_held", in_ready, 0);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 200)) @(posedge clk);
            #1;
            send(16'($urandom()), 16'($urandom()));
        end

        // Drop en mid-frame; frame completes, held pair survives idle
        wait_load();
        @(posedge clk); #1;
        send(16'($urandom()), 16'($urandom()));
        wait_k(5);
        en = 0;
        n = 0;
        while (low_cnt < DIV + 2 && n < 2 * FRAME) begin @(posedge clk); #1; n++; end
        chk("idle_reached", low_cnt >= DIV + 2, 1);
        repeat (3) @(posedge clk); #1;
        idle_outs("idle", 0);
        en = 1;
        wait_load();
        @(posedge clk); #1;
        chk("ready_restart", in_ready, 1);

        // Reset mid-frame
        wait_k(20);
        reset_n = 0;
        #1;
        idle_outs("midrst", 1);
        chk("midrst_under", underrun_cnt, 0);
        repeat (2) @(posedge clk); #1;
        sat_ones = 0; sat_phase = 1;
        reset_n = 1;

        // No samples at all: underrun counts per frame and saturates
        repeat (10) wait_load();
        chk("under10", underrun_cnt, 9);
        repeat (250) wait_load();
        @(posedge clk); #1;
        chk("under_sat", underrun_cnt, 255);
        chk("sdata_zero", sat_ones, 0);
        en = 0;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
